// File: rtl/polyz_pack_stream.sv
// Streaming z-polynomial packer: each signed coefficient pair becomes {GAMMA1-c1, GAMMA1-c0} in 20-bit fields, emitted as 5 bytes LSB first.
// Optional range checking of accepted coefficients is built when POLYZ_PACK_RANGECHK_EN is defined.
module polyz_pack_stream #(
  parameter int GAMMA1 = 524288,
  parameter int NPAIRS = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_c0,
  input  logic [31:0] in_c1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic        err_range
);

  localparam int FW = $clog2(GAMMA1) + 1;
  localparam int WW = 2 * FW;
  localparam int NB = WW / 8;
  localparam int PW = $clog2(NPAIRS);
  localparam logic [31:0] G1 = 32'(GAMMA1);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; out_byte/out_last are held stable while out_valid waits on out_ready.

  typedef enum logic {EMPTY, SHIFT} state_t;

  state_t          state;
  logic [WW-1:0]   word;
  logic [2:0]      byte_idx;
  logic [PW-1:0]   pair_cnt;
  logic            word_last;

  logic [FW-1:0]   t0;
  logic [FW-1:0]   t1;
  logic            last_byte;
  logic            out_xfer;
  logic            accept;

  assign t0 = FW'(G1 - in_c0);
  assign t1 = FW'(G1 - in_c1);

  assign last_byte = (byte_idx == 3'(NB - 1));
  assign out_valid = (state == SHIFT);
  assign out_byte  = word[7:0];
  assign out_last  = (state == SHIFT) && last_byte && word_last;
  assign out_xfer  = out_valid && out_ready;
  // A new pair may land in the same cycle the final byte of the previous word leaves.
  assign in_ready  = (state == EMPTY) || ((state == SHIFT) && last_byte && out_ready);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      word      <= '0;
      byte_idx  <= '0;
      pair_cnt  <= '0;
      word_last <= 1'b0;
    end else begin
      if (accept) begin
        state     <= SHIFT;
        word      <= {t1, t0};
        byte_idx  <= '0;
        word_last <= (pair_cnt == PW'(NPAIRS - 1));
        pair_cnt  <= (pair_cnt == PW'(NPAIRS - 1)) ? '0 : pair_cnt + 1'b1;
      end else if (out_xfer) begin
        if (last_byte) begin
          state     <= EMPTY;
          word      <= '0;
          byte_idx  <= '0;
          word_last <= 1'b0;
        end else begin
          word     <= word >> 8;
          byte_idx <= byte_idx + 3'd1;
        end
      end
    end
  end

`ifdef POLYZ_PACK_RANGECHK_EN
  localparam logic signed [31:0] C_HI = 32'(GAMMA1);
  localparam logic signed [31:0] C_LO = 32'(1 - GAMMA1);

  logic c0_ok;
  logic c1_ok;
  logic err_q;

  assign c0_ok = ($signed(in_c0) >= C_LO) && ($signed(in_c0) <= C_HI);
  assign c1_ok = ($signed(in_c1) >= C_LO) && ($signed(in_c1) <= C_HI);

  // Sticky; only a clean pair 0 of a fresh polynomial clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      if (!(c0_ok && c1_ok)) begin
        err_q <= 1'b1;
      end else if (pair_cnt == '0) begin
        err_q <= 1'b0;
      end
    end
  end

  assign err_range = err_q;
`else
  assign err_range = 1'b0;
`endif

endmodule
